// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Loads 15-bit instruction words into an instruction RAM from a
//               valid/ready byte stream (high byte first, then low byte).
//               Each word is written to consecutive RAM addresses, starting
//               at START_ADDR and wrapping modulo 256.
//               Optional read-back verify: define LOADER_VERIFY_EN to read
//               each word back after writing it and flag any mismatch on err.
// Ports       : clk, n_reset (async active-low)
//               start/length/abort  - load control
//               in_valid/in_data/in_ready - byte stream
//               ram_addr/ram_data/ram_wren/ram_q - instruction RAM
//               busy/done/err       - status
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [8:0]  length,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [7:0]  ram_addr,
    output logic [14:0] ram_data,
    output logic        ram_wren,
    input  logic [14:0] ram_q,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] c_s_idle  = 3'd0;
    localparam logic [2:0] c_s_hi    = 3'd1;
    localparam logic [2:0] c_s_lo    = 3'd2;
    localparam logic [2:0] c_s_write = 3'd3;
    localparam logic [2:0] c_s_done  = 3'd4;
`ifdef LOADER_VERIFY_EN
    localparam logic [2:0] c_s_rd    = 3'd5;
    localparam logic [2:0] c_s_cmp   = 3'd6;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [8:0]  r_len;
    logic [8:0]  r_count;
    logic [7:0]  r_addr;
    logic [14:0] r_data;
    logic        r_err;
    logic        r_in_ready;
    logic        r_wren;
    logic        r_busy;
    logic        r_done;

    logic        w_len_ok;
    logic        w_xfer;
    logic        w_last;
    logic        w_advance;

    assign w_len_ok = (length != 9'd0) && (length <= 9'd256);
    // r_in_ready is high exactly in HI and LO, so this is the handshake.
    assign w_xfer   = in_valid & r_in_ready;
    // count holds at most 255 here, so the 9-bit sum cannot overflow.
    assign w_last   = ((r_count + 9'd1) == r_len);

`ifdef LOADER_VERIFY_EN
    assign w_advance = (r_state == c_s_cmp) && !abort && !w_last;
`else
    assign w_advance = (r_state == c_s_write) && !abort && !w_last;
    // Read data is only consumed by the verify path.
    logic w_unused_ram_q;
    assign w_unused_ram_q = ^ram_q;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_s_idle:  if (start && w_len_ok) w_next = c_s_hi;
            c_s_hi: begin
                if (abort)       w_next = c_s_idle;
                else if (w_xfer) w_next = c_s_lo;
            end
            c_s_lo: begin
                if (abort)       w_next = c_s_idle;
                else if (w_xfer) w_next = c_s_write;
            end
            c_s_write: begin
                if (abort)       w_next = c_s_idle;
`ifdef LOADER_VERIFY_EN
                else             w_next = c_s_rd;
`else
                else if (w_last) w_next = c_s_done;
                else             w_next = c_s_hi;
`endif
            end
`ifdef LOADER_VERIFY_EN
            c_s_rd:  w_next = abort ? c_s_idle : c_s_cmp;
            c_s_cmp: begin
                if (abort)       w_next = c_s_idle;
                else if (w_last) w_next = c_s_done;
                else             w_next = c_s_hi;
            end
`endif
            c_s_done:  w_next = c_s_idle;
            default:   w_next = c_s_idle;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= c_s_idle;
            r_len      <= 9'd0;
            r_count    <= 9'd0;
            r_addr     <= 8'd0;
            r_data     <= 15'd0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
            r_wren     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            // Outputs are decoded from the next state so they line up with
            // the state register without any combinational output path.
            r_in_ready <= (w_next == c_s_hi) || (w_next == c_s_lo);
            r_wren     <= (w_next == c_s_write);
            r_busy     <= (w_next != c_s_idle) && (w_next != c_s_done);
            r_done     <= (w_next == c_s_done);

            case (r_state)
                c_s_idle: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_len   <= length;
                            r_addr  <= START_ADDR;
                            r_count <= 9'd0;
                            r_err   <= 1'b0;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end
                c_s_hi: begin
                    // Abort wins over a simultaneous transfer.
                    if (!abort && w_xfer) begin
                        r_data[14:8] <= in_data[6:0];
                        if (in_data[7]) r_err <= 1'b1;
                    end
                end
                c_s_lo: begin
                    if (!abort && w_xfer) r_data[7:0] <= in_data;
                end
`ifdef LOADER_VERIFY_EN
                c_s_cmp: begin
                    if (!abort && (ram_q != r_data)) r_err <= 1'b1;
                end
`endif
                default: ;
            endcase

            if (w_advance) begin
                r_addr  <= r_addr + 8'd1;
                r_count <= r_count + 9'd1;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign ram_addr = r_addr;
    assign ram_data = r_data;
    assign ram_wren = r_wren;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader. Two instances
//               share stimulus: one with START_ADDR=00, one with START_ADDR=FF
//               for the address wrap case. Each instance has its own RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       start = 1'b0;
    logic [8:0] length = 9'd0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;

    logic        in_ready0, ram_wren0, busy0, done0, err0;
    logic [7:0]  ram_addr0;
    logic [14:0] ram_data0, ram_q0;
    logic        in_ready_f, ram_wren_f, busy_f, done_f, err_f;
    logic [7:0]  ram_addr_f;
    logic [14:0] ram_data_f, ram_q_f;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

`ifdef LOADER_VERIFY_EN
    localparam int c_period = 5;
`else
    localparam int c_period = 3;
`endif

    always #5 clk = ~clk;

    prog_loader #(.START_ADDR(8'h00)) dut0 (
        .clk(clk), .n_reset(n_reset), .start(start), .length(length),
        .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .ram_addr(ram_addr0), .ram_data(ram_data0),
        .ram_wren(ram_wren0), .ram_q(ram_q0), .busy(busy0), .done(done0),
        .err(err0)
    );

    prog_loader #(.START_ADDR(8'hFF)) dut_ff (
        .clk(clk), .n_reset(n_reset), .start(start), .length(length),
        .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_f), .ram_addr(ram_addr_f), .ram_data(ram_data_f),
        .ram_wren(ram_wren_f), .ram_q(ram_q_f), .busy(busy_f), .done(done_f),
        .err(err_f)
    );

    // RAM models with registered read; mem0 can corrupt bit 0 of address 3.
    logic [14:0] mem0 [256];
    logic [14:0] mem_f [256];
    logic        corrupt = 1'b0;

    // Write/done monitors.
    logic [7:0]  wa0[$], wa_f[$];
    logic [14:0] wd0[$], wd_f[$];
    int          wt0[$];
    int          dc0 = 0, dc_f = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i]  = 15'd0;
            mem_f[i] = 15'd0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ram_wren0) begin
            mem0[ram_addr0] <= ram_data0;
            wa0.push_back(ram_addr0);
            wd0.push_back(ram_data0);
            wt0.push_back(cyc);
        end
        if (ram_wren_f) begin
            mem_f[ram_addr_f] <= ram_data_f;
            wa_f.push_back(ram_addr_f);
            wd_f.push_back(ram_data_f);
        end
        ram_q0  <= (corrupt && ram_addr0 == 8'd3) ? (mem0[ram_addr0] ^ 15'd1) : mem0[ram_addr0];
        ram_q_f <= mem_f[ram_addr_f];
        if (done0)  dc0  = dc0 + 1;
        if (done_f) dc_f = dc_f + 1;
    end

    task automatic clear_logs();
        wa0.delete(); wd0.delete(); wt0.delete();
        wa_f.delete(); wd_f.delete();
        dc0 = 0; dc_f = 0;
    endtask

    // Called at a negedge; returns at a negedge with start deasserted.
    task automatic start_load(input logic [8:0] len);
        start = 1'b1; length = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; leaves in_valid asserted, returns at a negedge.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        in_valid = 1'b1; in_data = b;
        for (int i = 0; i < 50; i++) begin
            if (in_ready0) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready0);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy0) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL wait_idle timeout: busy=%b required 0", busy0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        n_checks++;
        if ({in_ready0, ram_addr0, ram_data0, ram_wren0, busy0, done0, err0} !== 28'd0)
            $display("FAIL reset outputs dut0: got %h required 0",
                     {in_ready0, ram_addr0, ram_data0, ram_wren0, busy0, done0, err0});
        else n_pass++;
        n_checks++;
        if ({in_ready_f, ram_addr_f, ram_data_f, ram_wren_f, busy_f, done_f, err_f} !== 28'd0)
            $display("FAIL reset outputs dut_ff: got %h required 0",
                     {in_ready_f, ram_addr_f, ram_data_f, ram_wren_f, busy_f, done_f, err_f});
        else n_pass++;
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_logs();
        start_load(9'd2);
        n_checks++;
        if ({in_ready0, busy0, ram_addr0} !== {1'b1, 1'b1, 8'h00})
            $display("FAIL basic after start: ready/busy/addr=%b/%b/%h required 1/1/00",
                     in_ready0, busy0, ram_addr0);
        else n_pass++;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h01); send_byte(8'hFF);
        wait_idle();
        n_checks++;
        if (wa0.size() != 2) $display("FAIL basic write count: got %0d required 2", wa0.size());
        else begin
            n_pass++;
            n_checks++;
            if ({wa0[0], wd0[0], wa0[1], wd0[1]} !== {8'h00, 15'h1234, 8'h01, 15'h01FF})
                $display("FAIL basic writes: got %h:%h %h:%h required 00:1234 01:01ff",
                         wa0[0], wd0[0], wa0[1], wd0[1]);
            else n_pass++;
        end
        n_checks++;
        if ({dc0, err0, busy0} !== {32'd1, 1'b0, 1'b0})
            $display("FAIL basic status: done_cnt=%0d err=%b busy=%b required 1/0/0", dc0, err0, busy0);
        else n_pass++;
    endtask

    task automatic test_wrap();
        clear_logs();
        start_load(9'd2);
        send_byte(8'h0A); send_byte(8'hBC); send_byte(8'h7F); send_byte(8'h00);
        wait_idle();
        n_checks++;
        if (wa_f.size() != 2) $display("FAIL wrap write count: got %0d required 2", wa_f.size());
        else begin
            n_pass++;
            n_checks++;
            if ({wa_f[0], wd_f[0], wa_f[1], wd_f[1]} !== {8'hFF, 15'h0ABC, 8'h00, 15'h7F00})
                $display("FAIL wrap writes: got %h:%h %h:%h required ff:0abc 00:7f00",
                         wa_f[0], wd_f[0], wa_f[1], wd_f[1]);
            else n_pass++;
        end
        n_checks++;
        if ({dc_f, err_f} !== {32'd1, 1'b0})
            $display("FAIL wrap status: done_cnt=%0d err=%b required 1/0", dc_f, err_f);
        else n_pass++;
    endtask

    task automatic test_bad_length();
        clear_logs();
        start_load(9'd257);
        n_checks++;
        if ({err0, busy0, in_ready0} !== 3'b100)
            $display("FAIL len257: err/busy/ready=%b/%b/%b required 1/0/0", err0, busy0, in_ready0);
        else n_pass++;
        // A valid start clears the sticky error.
        start_load(9'd1);
        n_checks++;
        if ({err0, busy0} !== 2'b01)
            $display("FAIL err clear on start: err/busy=%b/%b required 0/1", err0, busy0);
        else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start_load(9'd0);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({err0, busy0, in_ready0, wa0.size(), dc0} !== {3'b100, 32'd0, 32'd0})
            $display("FAIL len0: err=%b busy=%b ready=%b writes=%0d done_cnt=%0d required 1/0/0/0/0",
                     err0, busy0, in_ready0, wa0.size(), dc0);
        else n_pass++;
    endtask

    task automatic test_format_err();
        clear_logs();
        start_load(9'd1);
        send_byte(8'h80); send_byte(8'h5A);
        wait_idle();
        n_checks++;
        if (wd0.size() != 1 || wd0[0] !== 15'h005A)
            $display("FAIL format word: writes=%0d data=%h required 1/005a",
                     wd0.size(), (wd0.size() > 0) ? wd0[0] : 15'h7FFF);
        else n_pass++;
        n_checks++;
        if ({err0, dc0} !== {1'b1, 32'd1})
            $display("FAIL format status: err=%b done_cnt=%0d required 1/1", err0, dc0);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        clear_logs();
        start_load(9'd1);
        start_load(9'd0);
        n_checks++;
        if ({err0, busy0, in_ready0, ram_addr0} !== {3'b011, 8'h00})
            $display("FAIL start ignored: err/busy/ready/addr=%b/%b/%b/%h required 0/1/1/00",
                     err0, busy0, in_ready0, ram_addr0);
        else n_pass++;
        send_byte(8'h11); send_byte(8'h22);
        wait_idle();
        n_checks++;
        if ({wa0.size(), dc0, err0} !== {32'd1, 32'd1, 1'b0})
            $display("FAIL start ignored result: writes=%0d done_cnt=%0d err=%b required 1/1/0",
                     wa0.size(), dc0, err0);
        else n_pass++;
    endtask

    task automatic test_abort();
        clear_logs();
        start_load(9'd3);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        // LO byte of word 2 arrives together with abort; abort must win.
        in_valid = 1'b1; in_data = 8'h78; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({busy0, in_ready0, ram_wren0} !== 3'b000)
            $display("FAIL abort idle: busy/ready/wren=%b/%b/%b required 0/0/0", busy0, in_ready0, ram_wren0);
        else n_pass++;
        n_checks++;
        if (ram_data0 !== 15'h5634)
            $display("FAIL abort priority data: got %h required 5634", ram_data0);
        else n_pass++;
        repeat (6) @(negedge clk);
        n_checks++;
        if ({wa0.size(), dc0, err0} !== {32'd1, 32'd0, 1'b0})
            $display("FAIL abort result: writes=%0d done_cnt=%0d err=%b required 1/0/0",
                     wa0.size(), dc0, err0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_logs();
        start_load(9'd4);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h20 + 8'(i));
            send_byte(8'h40 + 8'(i));
        end
        wait_idle();
        n_checks++;
        if (wa0.size() != 4) $display("FAIL b2b write count: got %0d required 4", wa0.size());
        else begin
            n_pass++;
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (wt0[i] - wt0[i-1] != c_period)
                    $display("FAIL b2b spacing %0d: got %0d required %0d", i, wt0[i] - wt0[i-1], c_period);
                else n_pass++;
            end
            n_checks++;
            if ({wa0[3], wd0[3]} !== {8'h03, 15'h2343})
                $display("FAIL b2b last write: got %h:%h required 03:2343", wa0[3], wd0[3]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midload();
        clear_logs();
        start_load(9'd2);
        send_byte(8'h33);
        n_reset = 1'b0;
        in_data = 8'h44;
        #1;
        n_checks++;
        if ({busy0, in_ready0, ram_wren0, ram_addr0} !== {3'b000, 8'h00})
            $display("FAIL midload reset: busy/ready/wren/addr=%b/%b/%b/%h required 0/0/0/00",
                     busy0, in_ready0, ram_wren0, ram_addr0);
        else n_pass++;
        @(negedge clk);
        n_reset = 1'b1;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({wa0.size(), dc0, busy0} !== {32'd0, 32'd0, 1'b0})
            $display("FAIL midload result: writes=%0d done_cnt=%0d busy=%b required 0/0/0",
                     wa0.size(), dc0, busy0);
        else n_pass++;
    endtask

`ifdef LOADER_VERIFY_EN
    task automatic test_verify();
        clear_logs();
        corrupt = 1'b1;
        start_load(9'd5);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(i));
            send_byte(8'h10 + 8'(i));
        end
        wait_idle();
        corrupt = 1'b0;
        n_checks++;
        if ({wa0.size(), dc0, err0} !== {32'd5, 32'd1, 1'b1})
            $display("FAIL verify: writes=%0d done_cnt=%0d err=%b required 5/1/1", wa0.size(), dc0, err0);
        else n_pass++;
        n_checks++;
        if (err_f !== 1'b0)
            $display("FAIL verify clean ram: err=%b required 0", err_f);
        else n_pass++;
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_bad_length();
        test_format_err();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_reset_midload();
`ifdef LOADER_VERIFY_EN
        test_verify();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
